// File: rtl/slave_arbiter_rr.sv
// slave_arbiter_rr: per-slave crossbar arbiter, fixed or round-robin with bounded lock hold
module slave_arbiter_rr #(
  parameter int NUM_MASTERS = 4,
  parameter int ARB_MODE = 1,
  parameter int MAX_LOCK_CYCLES = 16
) (
  input  logic                               i_Clk,
  input  logic                               i_Rst,
  input  logic [NUM_MASTERS-1:0]             i_Req,
  input  logic [NUM_MASTERS-1:0]             i_Lock,
  output logic [NUM_MASTERS-1:0]             o_Gnt,
  output logic [$clog2(NUM_MASTERS+1)-1:0]   o_MuxSel,
  output logic                               o_Busy,
  output logic                               o_LockTimeout
);
  localparam int SW = $clog2(NUM_MASTERS + 1);
  localparam int IW = $clog2(NUM_MASTERS);
  localparam int HW = (MAX_LOCK_CYCLES == 0) ? 1 : $clog2(MAX_LOCK_CYCLES + 1);
  localparam logic [HW-1:0] HMAX = HW'(MAX_LOCK_CYCLES);
  logic [SW-1:0] r_owner;
  logic [IW-1:0] r_ptr;
  logic [HW-1:0] r_hold_cnt;
  logic [IW-1:0] owner_idx, win;
  logic [NUM_MASTERS-1:0] owner_oh, req_m, gnt_c;
  logic [SW-1:0] sel_c;
  logic owner_lock, others, expired, cont, timeout, found;
  assign owner_idx = IW'(r_owner - SW'(1));
  assign owner_oh = (r_owner != '0) ? (NUM_MASTERS'(1) << owner_idx) : '0;
  assign owner_lock = (r_owner != '0) && i_Lock[owner_idx];
  assign others = |(i_Req & ~owner_oh);
  assign expired = (MAX_LOCK_CYCLES != 0) && (r_hold_cnt >= HMAX);
  assign cont = owner_lock && (!expired || !others);
  assign timeout = owner_lock && expired && others;
  assign req_m = timeout ? (i_Req & ~owner_oh) : i_Req;
  // Candidates are visited so the last hit is the winner: highest index, or nearest after r_ptr
  always_comb begin
    found = 1'b0;
    win = '0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      int j;
      j = (ARB_MODE == 0) ? (NUM_MASTERS - k) : ((int'(r_ptr) + k) % NUM_MASTERS);
      if (req_m[j]) begin
        found = 1'b1;
        win = IW'(j);
      end
    end
  end
  assign gnt_c = cont ? owner_oh : found ? (NUM_MASTERS'(1) << win) : '0;
  assign sel_c = cont ? r_owner : found ? SW'(win) + SW'(1) : '0;
  assign o_Gnt = i_Rst ? '0 : gnt_c;
  assign o_MuxSel = i_Rst ? '0 : sel_c;
  assign o_Busy = |o_Gnt;
  assign o_LockTimeout = !i_Rst && timeout;
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_owner <= '0;
      r_ptr <= IW'(NUM_MASTERS - 1);
      r_hold_cnt <= '0;
    end else if (cont) begin
      r_hold_cnt <= (MAX_LOCK_CYCLES == 0 || r_hold_cnt >= HMAX) ? r_hold_cnt : r_hold_cnt + HW'(1);
    end else if (found) begin
      r_owner <= SW'(win) + SW'(1);
      r_ptr <= win;
      r_hold_cnt <= HW'(1);
    end else begin
      r_owner <= '0;
      r_hold_cnt <= '0;
    end
  end
endmodule

// File: tb/tb_slave_arbiter_rr.sv
// tb_slave_arbiter_rr: directed vectors across round-robin, fixed and lock-timeout configurations
module tb_slave_arbiter_rr;
  logic clk = 0, rst = 1;
  logic [3:0] req = 0, lock = 0;
  logic [3:0] gnt [3];
  logic [2:0] sel [3];
  logic busy [3], to [3];
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  slave_arbiter_rr #(.NUM_MASTERS(4), .ARB_MODE(1), .MAX_LOCK_CYCLES(0)) u_rr (
    .i_Clk(clk), .i_Rst(rst), .i_Req(req), .i_Lock(lock),
    .o_Gnt(gnt[0]), .o_MuxSel(sel[0]), .o_Busy(busy[0]), .o_LockTimeout(to[0]));
  slave_arbiter_rr #(.NUM_MASTERS(4), .ARB_MODE(0), .MAX_LOCK_CYCLES(16)) u_fp (
    .i_Clk(clk), .i_Rst(rst), .i_Req(req), .i_Lock(lock),
    .o_Gnt(gnt[1]), .o_MuxSel(sel[1]), .o_Busy(busy[1]), .o_LockTimeout(to[1]));
  slave_arbiter_rr #(.NUM_MASTERS(4), .ARB_MODE(1), .MAX_LOCK_CYCLES(4)) u_lt (
    .i_Clk(clk), .i_Rst(rst), .i_Req(req), .i_Lock(lock),
    .o_Gnt(gnt[2]), .o_MuxSel(sel[2]), .o_Busy(busy[2]), .o_LockTimeout(to[2]));
  typedef struct {
    int d;
    logic rst;
    logic [3:0] req, lock;
    logic [2:0] sel;
    logic to;
  } vec_t;
  vec_t v [$];
  task automatic add(input int d, input logic r, input logic [3:0] q, input logic [3:0] l,
                     input logic [2:0] s, input logic t, input int n);
    for (int i = 0; i < n; i++) v.push_back('{d, r, q, l, s, t});
  endtask
  task automatic check(input string name, input int d, input logic [2:0] s, input logic t);
    logic [3:0] eg;
    eg = (s == 0) ? 4'b0 : (4'b1 << (s - 1));
    checks++;
    if (sel[d] !== s || gnt[d] !== eg || busy[d] !== (s != 0) || to[d] !== t) begin
      errors++;
      $display("FAIL %s dut%0d: sel=%0d gnt=%b busy=%b to=%b, want sel=%0d gnt=%b busy=%b to=%b",
               name, d, sel[d], gnt[d], busy[d], to[d], s, eg, s != 0, t);
    end
  endtask
  initial begin
    for (int d = 0; d < 3; d++) add(d, 1, 4'b1111, 0, 0, 0, 1);
    for (int d = 0; d < 3; d++) add(d, 0, 4'b0000, 0, 0, 0, 1);
    add(0, 0, 4'b1111, 0, 1, 0, 1);
    add(0, 0, 4'b1111, 0, 2, 0, 1);
    add(0, 0, 4'b1111, 0, 3, 0, 1);
    add(0, 0, 4'b1111, 0, 4, 0, 1);
    add(0, 0, 4'b1111, 0, 1, 0, 1);
    add(1, 0, 4'b0101, 0, 3, 0, 3);
    add(1, 0, 4'b0001, 0, 1, 0, 1);
    add(0, 1, 4'b0000, 0, 0, 0, 1);
    add(0, 0, 4'b0001, 4'b0001, 1, 0, 1);
    add(0, 0, 4'b1110, 4'b0001, 1, 0, 20);
    add(0, 0, 4'b1110, 4'b0000, 2, 0, 1);
    add(2, 1, 4'b0000, 0, 0, 0, 1);
    add(2, 0, 4'b1100, 4'b0100, 3, 0, 4);
    add(2, 0, 4'b1100, 4'b0100, 4, 1, 1);
    add(2, 0, 4'b1100, 4'b0100, 3, 0, 2);
    add(2, 1, 4'b0000, 0, 0, 0, 1);
    add(2, 0, 4'b0100, 4'b0100, 3, 0, 10);
    add(2, 1, 4'b0000, 0, 0, 0, 1);
    add(2, 0, 4'b0010, 4'b0010, 2, 0, 2);
    @(posedge clk);
    foreach (v[i]) begin
      #1;
      rst = v[i].rst; req = v[i].req; lock = v[i].lock;
      @(negedge clk);
      check($sformatf("vec%0d", i), v[i].d, v[i].sel, v[i].to);
      @(posedge clk);
    end
    #1;
    @(negedge clk);
    check("pre_async", 2, 2, 0);
    #2 rst = 1;
    #1 check("async_rst", 2, 0, 0);
    @(posedge clk);
    #1 rst = 0; req = 4'b0011; lock = 0;
    @(negedge clk);
    check("post_rst_rr", 2, 1, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("post_rst_rr2", 2, 2, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/slave_arbiter_rr.md
Name: slave_arbiter_rr

Overview:
- Parametrised per-slave arbiter for the crossbar; the next generation of the two-master fixed-priority slave arbiter.
- Supports any master count, selectable fixed-priority or round-robin policy, lock-based bus ownership, and a bounded lock hold time to prevent starvation.
- Grant and mux select are combinational from current requests plus registered ownership state, so a grant is issued in the same cycle as the request.
- Sits between the master request decode and the slave-side data mux of each crossbar slave port.

Parameters:
- NUM_MASTERS, 4: number of requesting masters (≥2).
- ARB_MODE, 1: 0 = fixed priority (highest index wins); 1 = round robin.
- MAX_LOCK_CYCLES, 16: maximum consecutive grant cycles one master may hold via lock while others request. 0 = unlimited.

Ports:
- i_Clk  in  1  clock.
- i_Rst  in  1  asynchronous reset, active-high.
- i_Req  in  NUM_MASTERS  per-master request.
- i_Lock  in  NUM_MASTERS  per-master ownership hold.
- o_Gnt  out  NUM_MASTERS  one-hot grant; all zero when idle.
- o_MuxSel  out  $clog2(NUM_MASTERS+1)  0 = none, k = master k-1 selected.
- o_Busy  out  1  |o_Gnt.
- o_LockTimeout  out  1  high in any cycle where a lock is overridden.

Behaviour:
- Registered state:
  - r_Owner (MuxSel encoding; reset 0).
  - r_Ptr (index of last granted master; reset NUM_MASTERS-1, so master 0 wins first in RR).
  - r_HoldCnt (width $clog2(MAX_LOCK_CYCLES+1), min 1; reset 0).
- Reset: o_Gnt=0, o_MuxSel=0, o_Busy=0, o_LockTimeout=0 while i_Rst high, regardless of i_Req. Reset mid-transaction drops ownership immediately and asynchronously.
- Each cycle, the decision is one of CONTINUE, ARBITRATE or IDLE:
  - CONTINUE: r_Owner≠0 and i_Lock[r_Owner-1]=1, and either MAX_LOCK_CYCLES=0, or r_HoldCnt<MAX_LOCK_CYCLES, or no other master has i_Req set.
    - Grant stays on r_Owner; i_Req of the owner is ignored.
    - r_HoldCnt ← r_HoldCnt+1, saturating at MAX_LOCK_CYCLES.
  - Forced release: owner locked, r_HoldCnt≥MAX_LOCK_CYCLES (MAX≠0), and another master requests.
    - o_LockTimeout=1.
    - Arbitrate with the owner's request masked out for this cycle.
  - ARBITRATE: choose among i_Req (masked as above).
    - ARB_MODE=0: highest set index wins.
    - ARB_MODE=1: first set index searching r_Ptr+1, r_Ptr+2, … with wrap modulo NUM_MASTERS; r_Ptr itself is checked last.
    - On grant: r_Owner←idx+1, r_Ptr←idx, r_HoldCnt←1.
  - IDLE (no eligible request): outputs 0; r_Owner←0, r_HoldCnt←0, r_Ptr unchanged.
- Lock without a current grant has no effect; lock alone never creates a grant.
- A non-locking owner with i_Req still high re-arbitrates each cycle.
  - RR: the owner yields to any other requester and is re-granted only if it is the sole requester.
  - Fixed: the owner keeps the grant only if it is still highest priority.
- o_Gnt is always one-hot or zero; o_MuxSel is always consistent with o_Gnt.
- Latency: zero-cycle request→grant; ownership state updates on the clock edge.

Test Plan:
- Reset/idle: assert i_Rst with i_Req=4'b1111 → o_Gnt=0, o_MuxSel=0. Release reset, hold i_Req=0 → outputs stay 0.
- Round robin: ARB_MODE=1, i_Req=4'b1111 held, no lock, 5 cycles → o_MuxSel sequence 1,2,3,4,1.
- Fixed priority: ARB_MODE=0, i_Req=4'b0101 → o_MuxSel=3 every cycle. Drop i_Req[2] → o_MuxSel=1 the same cycle.
- Lock hold: ARB_MODE=1, master0 granted with i_Lock[0]=1, then i_Req=4'b1110 and MAX_LOCK_CYCLES=0 → o_MuxSel=1 until i_Lock[0] falls, then 2 in that cycle.
- Lock timeout: MAX_LOCK_CYCLES=4, master2 locked, i_Req[3]=1 from first grant → master2 granted exactly 4 cycles; 5th cycle o_MuxSel=4 and o_LockTimeout=1 for one cycle. The same case with no other requester → master2 keeps the grant indefinitely and o_LockTimeout stays 0.
- Async reset mid-lock: master1 locked, assert i_Rst between clock edges → o_Gnt=0 immediately. After release with i_Req=4'b0011 in RR mode → master0 granted first.
